// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : traffic_pkg
// Description : Shared constants for the traffic-light controller slice.
//               Holds the car-sense filter state encoding and its default
//               parameter values, next to the controller colour constants.
// Revision    : 1.0 - initial release
// ============================================================================
package traffic_pkg;

    // Default sizing for car_sense_filter
    localparam int c_DEB_CYCLES_DEF  = 16;
    localparam int c_HOLD_CYCLES_DEF = 8;
    localparam int c_CNT_W_DEF       = 8;

    // Car-sense filter state encoding (visible on state_dbg)
    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_DEB_ON  = 3'd1;
    localparam logic [2:0] c_ST_PRESENT = 3'd2;
    localparam logic [2:0] c_ST_DEB_OFF = 3'd3;
    localparam logic [2:0] c_ST_HOLD    = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE    = c_ST_IDLE,
        ST_DEB_ON  = c_ST_DEB_ON,
        ST_PRESENT = c_ST_PRESENT,
        ST_DEB_OFF = c_ST_DEB_OFF,
        ST_HOLD    = c_ST_HOLD
    } sense_state_e;

    // Controller lamp colours
    localparam logic [1:0] c_COL_RED    = 2'd0;
    localparam logic [1:0] c_COL_YELLOW = 2'd1;
    localparam logic [1:0] c_COL_GREEN  = 2'd2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync2.sv
`default_nettype none
// ============================================================================
// Module      : sync2
// Description : Two-flop synchroniser for a single asynchronous bit, cleared
//               to 0 by reset. Also usable for reset conditioning.
// Ports       : clk - sampling clock
//               rst - synchronous active-low reset
//               d   - asynchronous input
//               q   - synchronised output
// Revision    : 1.0 - initial release
// ============================================================================
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_meta <= 1'b0;
            r_q    <= 1'b0;
        end else begin
            r_meta <= d;
            r_q    <= r_meta;
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/car_sense_filter.sv
`default_nettype none
// ============================================================================
// Module      : car_sense_filter
// Description : Synchronises and debounces the vehicle sensor, stretches
//               departures by a hold time, pulses on each accepted arrival
//               and keeps a saturating arrival count.
// Ports       : clk       - block clock (rising edge)
//               rst       - synchronous active-low reset
//               car_raw   - asynchronous, bouncing sensor input
//               count_clr - synchronous clear of car_count
//               car       - filtered presence (registered)
//               car_rise  - one-cycle pulse per accepted arrival
//               car_count - saturating arrival count
//               state_dbg - current FSM state encoding
// Revision    : 1.0 - initial release
// ============================================================================
module car_sense_filter
    import traffic_pkg::*;
#(
    parameter int DEB_CYCLES  = c_DEB_CYCLES_DEF,
    parameter int HOLD_CYCLES = c_HOLD_CYCLES_DEF,
    parameter int CNT_W       = c_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             car_raw,
    input  logic             count_clr,
    output logic             car,
    output logic             car_rise,
    output logic [CNT_W-1:0] car_count,
    output logic [2:0]       state_dbg
);

    // Timer only ever needs to reach max(DEB, HOLD) - 1
    localparam int c_SPAN = max_int(DEB_CYCLES, HOLD_CYCLES);
    localparam int c_TW   = $clog2(c_SPAN);

    localparam logic [c_TW-1:0]  c_T_MAX     = c_TW'(c_SPAN - 1);
    localparam logic [c_TW-1:0]  c_DEB_LAST  = c_TW'(DEB_CYCLES - 2);
    localparam logic [c_TW-1:0]  c_HOLD_LAST = c_TW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
    localparam logic             c_HOLD_EN   = (HOLD_CYCLES > 0);
    localparam logic [CNT_W-1:0] c_CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);

    logic             w_s;
    sense_state_e     r_state;
    sense_state_e     w_state_nx;
    logic [c_TW-1:0]  r_tmr;
    logic [c_TW-1:0]  w_tmr_nx;
    logic             w_car_nx;
    logic             r_car;
    logic             r_car_rise;
    logic [CNT_W-1:0] r_count;

    sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (car_raw),
        .q   (w_s)
    );

    // Next-state and timer logic. The transition test happens one cycle
    // before the timer would reach DEB_CYCLES-1, because the entry cycle
    // into DEB_ON/DEB_OFF already counts as one stable sample.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_s) w_state_nx = ST_DEB_ON;
            end
            ST_DEB_ON: begin
                if (!w_s)                     w_state_nx = ST_IDLE;
                else if (r_tmr == c_DEB_LAST) w_state_nx = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (!w_s) w_state_nx = ST_DEB_OFF;
            end
            ST_DEB_OFF: begin
                if (w_s)                      w_state_nx = ST_PRESENT;
                else if (r_tmr == c_DEB_LAST) w_state_nx = c_HOLD_EN ? ST_HOLD : ST_IDLE;
            end
            ST_HOLD: begin
                if (w_s)                       w_state_nx = ST_PRESENT;
                else if (r_tmr == c_HOLD_LAST) w_state_nx = ST_IDLE;
            end
            default: w_state_nx = ST_IDLE;
        endcase

        if (w_state_nx != r_state)
            w_tmr_nx = '0;
        else if (r_tmr == c_T_MAX)
            w_tmr_nx = r_tmr;
        else
            w_tmr_nx = r_tmr + 1'b1;

        // Presence follows the current state, one register stage behind it
        w_car_nx = (r_state == ST_PRESENT) || (r_state == ST_DEB_OFF) ||
                   (r_state == ST_HOLD);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_tmr      <= '0;
            r_car      <= 1'b0;
            r_car_rise <= 1'b0;
            r_count    <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_tmr      <= w_tmr_nx;
            r_car      <= w_car_nx;
            // car can only rise via DEB_ON->PRESENT; re-entries from
            // DEB_OFF/HOLD keep car high, so no pulse is produced for them
            r_car_rise <= w_car_nx && !r_car;
            if (count_clr)
                r_count <= r_car_rise ? c_CNT_ONE : '0;
            else if (r_car_rise && (r_count != c_CNT_MAX))
                r_count <= r_count + 1'b1;
        end
    end

    assign car       = r_car;
    assign car_rise  = r_car_rise;
    assign car_count = r_count;
    assign state_dbg = r_state;

endmodule
`default_nettype wire

// File: tb/tb_car_sense_filter.sv
`default_nettype none
// ============================================================================
// Module      : tb_car_sense_filter
// Description : Self-checking bench for car_sense_filter. Main instance uses
//               DEB_CYCLES=4, HOLD_CYCLES=3; a second instance has the hold
//               disabled. Accepted arrivals are predicted into a queue and
//               matched cycle-exactly against car_rise pulses.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_car_sense_filter;

    logic       clk = 1'b0;
    logic       rst;
    logic       car_raw;
    logic       count_clr;
    logic       car;
    logic       car_rise;
    logic [7:0] car_count;
    logic [2:0] state_dbg;

    logic       car_raw0;
    logic       count_clr0;
    logic       car0;
    logic       car_rise0;
    logic [7:0] car_count0;
    logic [2:0] state_dbg0;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int exp_q[$];
    bit seen4    = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    car_sense_filter #(.DEB_CYCLES(4), .HOLD_CYCLES(3), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .car_raw   (car_raw),
        .count_clr (count_clr),
        .car       (car),
        .car_rise  (car_rise),
        .car_count (car_count),
        .state_dbg (state_dbg)
    );

    car_sense_filter #(.DEB_CYCLES(4), .HOLD_CYCLES(0), .CNT_W(8)) dut_h0 (
        .clk       (clk),
        .rst       (rst),
        .car_raw   (car_raw0),
        .count_clr (count_clr0),
        .car       (car0),
        .car_rise  (car_rise0),
        .car_count (car_count0),
        .state_dbg (state_dbg0)
    );

    // Scoreboard: every car_rise pulse must match the next predicted cycle
    always @(negedge clk) begin
        if (car_rise === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL rise_scoreboard: unexpected car_rise at cycle %0d, none expected", cyc);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (cyc !== e) begin
                    failures++;
                    $display("FAIL rise_scoreboard: car_rise at cycle %0d, expected cycle %0d", cyc, e);
                end
            end
        end
        if (state_dbg0 == 3'd4) seen4 = 1'b1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    // Rise appears 7 negedges after the drive: capture edge + 6
    task automatic do_arrive();
        car_raw = 1'b1;
        exp_q.push_back(cyc + 7);
        repeat (8) @(negedge clk);
    endtask

    task automatic do_depart();
        car_raw = 1'b0;
        repeat (11) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; car_raw = 1'b1; count_clr = 1'b0;
        car_raw0 = 1'b0; count_clr0 = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (car !== 1'b0) begin failures++; $display("FAIL reset_car: got %0b expected 0", car); end
        checks++; if (car_rise !== 1'b0) begin failures++; $display("FAIL reset_rise: got %0b expected 0", car_rise); end
        checks++; if (car_count !== 8'd0) begin failures++; $display("FAIL reset_count: got %0d expected 0", car_count); end
        checks++; if (state_dbg !== 3'd0) begin failures++; $display("FAIL reset_state: got %0d expected 0", state_dbg); end
        car_raw = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_arrival();
        car_raw = 1'b1;
        exp_q.push_back(cyc + 7);
        repeat (6) @(negedge clk);
        checks++; if (car !== 1'b0) begin failures++; $display("FAIL arrival_early: car got %0b expected 0", car); end
        @(negedge clk);
        checks++; if (car !== 1'b1) begin failures++; $display("FAIL arrival_car: got %0b expected 1", car); end
        checks++; if (car_rise !== 1'b1) begin failures++; $display("FAIL arrival_rise: got %0b expected 1", car_rise); end
        @(negedge clk);
        checks++; if (car_rise !== 1'b0) begin failures++; $display("FAIL arrival_rise_width: got %0b expected 0", car_rise); end
        checks++; if (car_count !== 8'd1) begin failures++; $display("FAIL arrival_count: got %0d expected 1", car_count); end
        checks++; if (state_dbg !== 3'd2) begin failures++; $display("FAIL arrival_state: got %0d expected 2", state_dbg); end
    endtask

    task automatic test_departure();
        car_raw = 1'b0;
        repeat (6) @(negedge clk);
        checks++; if (state_dbg !== 3'd4) begin failures++; $display("FAIL depart_hold_state: got %0d expected 4", state_dbg); end
        repeat (3) @(negedge clk);
        checks++; if (car !== 1'b1) begin failures++; $display("FAIL depart_early: car got %0b expected 1", car); end
        @(negedge clk);
        checks++; if (car !== 1'b0) begin failures++; $display("FAIL depart_car: got %0b expected 0", car); end
        checks++; if (state_dbg !== 3'd0) begin failures++; $display("FAIL depart_state: got %0d expected 0", state_dbg); end
        checks++; if (car_count !== 8'd1) begin failures++; $display("FAIL depart_count: got %0d expected 1", car_count); end
    endtask

    task automatic test_hold_reentry();
        bit dropped;
        dropped = 1'b0;
        do_arrive();
        car_raw = 1'b0;
        repeat (5) @(negedge clk);
        car_raw = 1'b1;
        @(negedge clk);
        checks++; if (state_dbg !== 3'd4) begin failures++; $display("FAIL reentry_hold: state got %0d expected 4", state_dbg); end
        for (int i = 0; i < 6; i++) begin
            if (car !== 1'b1) dropped = 1'b1;
            @(negedge clk);
        end
        checks++; if (dropped !== 1'b0) begin failures++; $display("FAIL reentry_car: car dropped=%0b expected 0", dropped); end
        checks++; if (state_dbg !== 3'd2) begin failures++; $display("FAIL reentry_state: got %0d expected 2", state_dbg); end
        checks++; if (car_count !== 8'd2) begin failures++; $display("FAIL reentry_count: got %0d expected 2", car_count); end
    endtask

    task automatic test_short_pulse();
        bit rose;
        rose = 1'b0;
        do_depart();
        car_raw = 1'b1;
        repeat (3) @(negedge clk);
        car_raw = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (car !== 1'b0) rose = 1'b1;
            @(negedge clk);
        end
        checks++; if (rose !== 1'b0) begin failures++; $display("FAIL short_pulse_car: car rose=%0b expected 0", rose); end
        checks++; if (car_count !== 8'd2) begin failures++; $display("FAIL short_pulse_count: got %0d expected 2", car_count); end
    endtask

    task automatic test_bounce();
        bit bpat [9] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 9; i++) begin
            car_raw = bpat[i];
            if (i == 5) exp_q.push_back(cyc + 7);
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        checks++; if (car !== 1'b0) begin failures++; $display("FAIL bounce_early: car got %0b expected 0", car); end
        @(negedge clk);
        checks++; if (car !== 1'b1) begin failures++; $display("FAIL bounce_car: got %0b expected 1", car); end
        repeat (2) @(negedge clk);
        checks++; if (car_count !== 8'd3) begin failures++; $display("FAIL bounce_count: got %0d expected 3", car_count); end
        do_depart();
    endtask

    task automatic test_reset_mid();
        do_arrive();
        car_raw = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (state_dbg !== 3'd3) begin failures++; $display("FAIL midrst_debof: state got %0d expected 3", state_dbg); end
        rst = 1'b0;
        car_raw = 1'b1;
        @(negedge clk);
        checks++; if (car !== 1'b0) begin failures++; $display("FAIL midrst_car: got %0b expected 0", car); end
        checks++; if (state_dbg !== 3'd0) begin failures++; $display("FAIL midrst_state: got %0d expected 0", state_dbg); end
        checks++; if (car_count !== 8'd0) begin failures++; $display("FAIL midrst_count: got %0d expected 0", car_count); end
        rst = 1'b1;
        exp_q.push_back(cyc + 7);
        repeat (6) @(negedge clk);
        checks++; if (car !== 1'b0) begin failures++; $display("FAIL midrst_early: car got %0b expected 0", car); end
        @(negedge clk);
        checks++; if (car !== 1'b1) begin failures++; $display("FAIL midrst_reassert: car got %0b expected 1", car); end
        repeat (2) @(negedge clk);
        checks++; if (car_count !== 8'd1) begin failures++; $display("FAIL midrst_recount: got %0d expected 1", car_count); end
        do_depart();
    endtask

    task automatic test_saturation();
        count_clr = 1'b1;
        @(negedge clk);
        count_clr = 1'b0;
        checks++; if (car_count !== 8'd0) begin failures++; $display("FAIL clr_alone: got %0d expected 0", car_count); end
        for (int n = 0; n < 256; n++) begin
            do_arrive();
            do_depart();
        end
        checks++; if (car_count !== 8'd255) begin failures++; $display("FAIL saturate: got %0d expected 255", car_count); end
        car_raw = 1'b1;
        exp_q.push_back(cyc + 7);
        repeat (7) @(negedge clk);
        checks++; if (car_rise !== 1'b1) begin failures++; $display("FAIL clr_rise_present: got %0b expected 1", car_rise); end
        count_clr = 1'b1;
        @(negedge clk);
        count_clr = 1'b0;
        checks++; if (car_count !== 8'd1) begin failures++; $display("FAIL clr_with_rise: got %0d expected 1", car_count); end
        do_depart();
    endtask

    task automatic test_hold0();
        car_raw0 = 1'b1;
        repeat (7) @(negedge clk);
        checks++; if (car0 !== 1'b1) begin failures++; $display("FAIL h0_arrive_car: got %0b expected 1", car0); end
        checks++; if (car_rise0 !== 1'b1) begin failures++; $display("FAIL h0_arrive_rise: got %0b expected 1", car_rise0); end
        car_raw0 = 1'b0;
        repeat (6) @(negedge clk);
        checks++; if (car0 !== 1'b1) begin failures++; $display("FAIL h0_depart_early: car got %0b expected 1", car0); end
        @(negedge clk);
        checks++; if (car0 !== 1'b0) begin failures++; $display("FAIL h0_depart_car: got %0b expected 0", car0); end
        checks++; if (car_count0 !== 8'd1) begin failures++; $display("FAIL h0_count: got %0d expected 1", car_count0); end
        repeat (3) @(negedge clk);
        checks++; if (seen4 !== 1'b0) begin failures++; $display("FAIL h0_no_hold: seen state 4=%0b expected 0", seen4); end
    endtask

    initial begin
        test_reset();
        test_arrival();
        test_departure();
        test_hold_reentry();
        test_short_pulse();
        test_bounce();
        test_reset_mid();
        test_saturation();
        test_hold0();
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() !== 0) begin
            failures++;
            $display("FAIL rise_scoreboard_drain: %0d predicted rises missing, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/car_sense_filter.md
CAR_SENSE_FILTER -- requirements
Module: car_sense_filter

Interface
REQ-001 Parameter DEB_CYCLES, default 16: consecutive stable synchronised samples needed to accept a level change; legal range 2..65535.
REQ-002 Parameter HOLD_CYCLES, default 8: cycles `car` stays asserted after an accepted departure; 0 disables the hold.
REQ-003 Parameter CNT_W, default 8: width of the arrival counter.
REQ-004 clk  input  1  single block clock, the divided traffic-controller clock; all logic on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 car_raw  input  1  unsynchronised vehicle sensor/button, may bounce.
REQ-007 count_clr  input  1  synchronous clear of car_count, single-cycle pulse or level.
REQ-008 car  output  1  filtered presence, feeds the controller's car input directly.
REQ-009 car_rise  output  1  one-cycle pulse per accepted arrival.
REQ-010 car_count  output  CNT_W  saturating number of accepted arrivals.
REQ-011 state_dbg  output  3  current FSM state encoding.

Function
REQ-012 car_raw SHALL pass through a 2-flop synchroniser; its output is s, and no other logic reads car_raw.
REQ-013 FSM states, encoded 0..4: IDLE, DEB_ON, PRESENT, DEB_OFF, HOLD.
REQ-014 One debounce/hold counter SHALL run, DEB_CYCLES/HOLD_CYCLES-sized, cleared on every state change, incrementing each cycle the state is unchanged.
REQ-015 IDLE: s=1 -> DEB_ON; otherwise stay.
REQ-016 DEB_ON: s=0 -> IDLE; s=1 with counter = DEB_CYCLES-2 -> PRESENT, so s=1 for DEB_CYCLES consecutive cycles is required.
REQ-017 PRESENT: s=0 -> DEB_OFF; otherwise stay.
REQ-018 DEB_OFF: s=1 -> PRESENT with no new car_rise; s=0 with counter = DEB_CYCLES-2 -> HOLD, or -> IDLE if HOLD_CYCLES=0.
REQ-019 HOLD: s=1 -> PRESENT with no new car_rise; counter = HOLD_CYCLES-1 -> IDLE.
REQ-020 car SHALL be registered, 1 exactly while the state is PRESENT, DEB_OFF or HOLD.
REQ-021 car_rise SHALL be 1 for exactly the first cycle car is 1 after the DEB_ON->PRESENT transition, never on DEB_OFF/HOLD->PRESENT re-entry.
REQ-022 Latency: a clean car_raw 0->1 step SHALL assert car exactly DEB_CYCLES+2 cycles after the first sampling edge that captures it.
REQ-023 Pulses shorter than DEB_CYCLES synchronised cycles SHALL leave car, car_rise and car_count unchanged.
REQ-024 car_count SHALL increment on car_rise and saturate at 2^CNT_W-1 with no wrap.
REQ-025 count_clr with car_rise in the same cycle SHALL load car_count=1; count_clr alone SHALL load 0.
REQ-026 The counter SHALL never exceed max(DEB_CYCLES, HOLD_CYCLES)-1, and its width is derived with $clog2.

Reset
REQ-027 With rst=0 at a clock edge: synchroniser flops 0, state IDLE, counter 0, car 0, car_rise 0, car_count 0.
REQ-028 Reset SHALL take priority over all other inputs, including mid-debounce and mid-hold; after release, a held-high car_raw SHALL be re-debounced from IDLE with full latency.

Structure
REQ-029 State encoding localparams and default parameter values SHALL live in the shared package traffic_pkg, alongside the controller's colour/state constants.
REQ-030 The synchroniser SHALL be a separate sub-module sync2 (1-bit, reset to 0), reusable for Reset conditioning; everything else stays in car_sense_filter.
REQ-031 The top level SHALL instantiate car_sense_filter between the board input and the Timer/State car inputs.

Verification (DEB_CYCLES=4, HOLD_CYCLES=3, CNT_W=8 unless stated)
REQ-032 car_raw 0->1 held -> car=1 and car_rise pulse exactly 6 cycles after first capture; car_count=1.
REQ-033 car_raw bounces 1,0,1,1,0,1,1,1,1 -> single car_rise, car_count=1, car asserts only after 4 consecutive synchronised 1s.
REQ-034 Departure: car_raw 1->0 held -> car falls 2+4+3 = 9 cycles after first capture of 0; re-raise car_raw during HOLD -> car stays 1, no car_rise, count unchanged.
REQ-035 HOLD_CYCLES=0: departure -> car falls 6 cycles after first capture; state_dbg never shows 4.
REQ-036 256 clean arrivals with CNT_W=8 -> car_count stops at 255; count_clr coincident with car_rise -> car_count=1.
REQ-037 rst=0 asserted while in DEB_OFF with car=1 -> next edge car=0, state_dbg=0, car_count=0; car_raw still high -> car reasserts 6 cycles after release.
